// File: rtl/sram_2p_sync_bm.sv
// sram_2p_sync_bm: single-clock true dual-port behavioural SRAM model.
//
// Each port has its own BIST input mux. Writes are bit-group masked, and the
// read-during-write behaviour is selectable. The read data path has an
// optional output register. A write-write arbiter merges same-address writes
// and gives the P_COLL_PRIO port priority.
//
// Optional feature macro: SRAM_2P_COLL_CHK_EN
//   defined   -> the collision detector drives COLL_FLAG (sticky) and
//                COLL_CNT (saturating at 255). COLL_CLR clears both.
//   undefined -> COLL_FLAG and COLL_CNT are tied to 0 and COLL_CLR is ignored.
//
// Ports (X = A, B):
//   CLK, RST_N         clock, asynchronous active-low reset
//   X_MEN/WEN/REN      port enable, write, read
//   X_ADDR, X_DIN      address, write data
//   X_BM               write mask, one bit per P_MASK_GRAN data bits
//   X_BIST_EN          selects the X_BIST_* inputs for this port
//   X_BIST_*           BIST-side copies of the functional inputs
//   X_DOUT, X_DVAL     read data, one-cycle pulse when a read updates X_DOUT
//   COLL_CLR           synchronous clear of the collision flag and counter
//   COLL_FLAG          sticky collision indicator
//   COLL_CNT           saturating collision event count
module sram_2p_sync_bm #(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 10,
  parameter int unsigned P_ADDR_COUNT = 2 ** P_ADDR_WIDTH,
  parameter int unsigned P_MASK_GRAN  = 1,
  parameter int unsigned P_RDW_MODE   = 0,
  parameter int unsigned P_OUT_REG    = 0,
  parameter int unsigned P_COLL_PRIO  = 0,
  localparam int unsigned MW = P_DATA_WIDTH / P_MASK_GRAN
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    A_MEN,
  input  logic                    A_WEN,
  input  logic                    A_REN,
  input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
  input  logic [P_DATA_WIDTH-1:0] A_DIN,
  input  logic [MW-1:0]           A_BM,
  input  logic                    A_BIST_EN,
  input  logic                    A_BIST_MEN,
  input  logic                    A_BIST_WEN,
  input  logic                    A_BIST_REN,
  input  logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  input  logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  input  logic [MW-1:0]           A_BIST_BM,
  output logic [P_DATA_WIDTH-1:0] A_DOUT,
  output logic                    A_DVAL,
  input  logic                    B_MEN,
  input  logic                    B_WEN,
  input  logic                    B_REN,
  input  logic [P_ADDR_WIDTH-1:0] B_ADDR,
  input  logic [P_DATA_WIDTH-1:0] B_DIN,
  input  logic [MW-1:0]           B_BM,
  input  logic                    B_BIST_EN,
  input  logic                    B_BIST_MEN,
  input  logic                    B_BIST_WEN,
  input  logic                    B_BIST_REN,
  input  logic [P_ADDR_WIDTH-1:0] B_BIST_ADDR,
  input  logic [P_DATA_WIDTH-1:0] B_BIST_DIN,
  input  logic [MW-1:0]           B_BIST_BM,
  output logic [P_DATA_WIDTH-1:0] B_DOUT,
  output logic                    B_DVAL,
  input  logic                    COLL_CLR,
  output logic                    COLL_FLAG,
  output logic [7:0]              COLL_CNT
);

  localparam int unsigned DW = P_DATA_WIDTH;
  localparam int unsigned AW = P_ADDR_WIDTH;
  localparam logic [AW:0] AddrCount = (AW + 1)'(P_ADDR_COUNT);

  // Index 0 is port A and index 1 is port B.
  logic [1:0]          men, wen, ren, valid, wr, rd;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  din, bmx, old, merged, wr_word, rd_data;
  logic [1:0][MW-1:0]  bm;
  logic                ww_hit;
  logic [DW-1:0]       a_take, b_take, ww_word;

  logic [DW-1:0] mem [P_ADDR_COUNT];

  // BIST input mux, one per port
  always_comb begin
    men[0]  = A_BIST_EN ? A_BIST_MEN  : A_MEN;
    wen[0]  = A_BIST_EN ? A_BIST_WEN  : A_WEN;
    ren[0]  = A_BIST_EN ? A_BIST_REN  : A_REN;
    addr[0] = A_BIST_EN ? A_BIST_ADDR : A_ADDR;
    din[0]  = A_BIST_EN ? A_BIST_DIN  : A_DIN;
    bm[0]   = A_BIST_EN ? A_BIST_BM   : A_BM;
    men[1]  = B_BIST_EN ? B_BIST_MEN  : B_MEN;
    wen[1]  = B_BIST_EN ? B_BIST_WEN  : B_WEN;
    ren[1]  = B_BIST_EN ? B_BIST_REN  : B_REN;
    addr[1] = B_BIST_EN ? B_BIST_ADDR : B_ADDR;
    din[1]  = B_BIST_EN ? B_BIST_DIN  : B_DIN;
    bm[1]   = B_BIST_EN ? B_BIST_BM   : B_BM;
  end

  // Per-port decode, mask expansion and single-port merge
  always_comb begin
    valid  = '0;
    wr     = '0;
    rd     = '0;
    bmx    = '0;
    old    = '0;
    merged = '0;
    for (int p = 0; p < 2; p++) begin
      valid[p] = {1'b0, addr[p]} < AddrCount;
      // Writes are held off during reset and dropped when out of range.
      wr[p]    = RST_N & men[p] & wen[p] & valid[p];
      rd[p]    = men[p] & ren[p];
      for (int g = 0; g < int'(MW); g++) begin
        bmx[p][g*P_MASK_GRAN +: P_MASK_GRAN] = {P_MASK_GRAN{bm[p][g]}};
      end
      old[p]    = valid[p] ? mem[addr[p]] : '0;
      merged[p] = (old[p] & ~bmx[p]) | (din[p] & bmx[p]);
    end
  end

  // Write-write arbiter: groups that both ports mask go to the priority port.
  always_comb begin
    ww_hit  = wr[0] & wr[1] & (addr[0] == addr[1]);
    a_take  = (P_COLL_PRIO == 0) ? bmx[0] : (bmx[0] & ~bmx[1]);
    b_take  = bmx[1] & ~a_take;
    ww_word = (old[0] & ~(bmx[0] | bmx[1])) | (din[0] & a_take) | (din[1] & b_take);
    for (int p = 0; p < 2; p++) begin
      wr_word[p] = ww_hit ? ww_word : merged[p];
      // A cross-port write never affects this port's read, so only the
      // port's own write can feed the new word back to it.
      if (!valid[p]) begin
        rd_data[p] = '0;
      end else if (wr[p] && (P_RDW_MODE == 0)) begin
        rd_data[p] = wr_word[p];
      end else begin
        rd_data[p] = old[p];
      end
    end
  end

  // The memory array has no reset; its contents start as X.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      if (wr[p]) begin
        mem[addr[p]] <= wr_word[p];
      end
    end
  end

  logic [1:0]         dval_q;
  logic [1:0][DW-1:0] dout_q;

  if (P_OUT_REG != 0) begin : g_out_reg
    logic [1:0]         pipe_val_q;
    logic [1:0][DW-1:0] pipe_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        pipe_val_q <= '0;
        pipe_q     <= '0;
        dval_q     <= '0;
        dout_q     <= '0;
      end else begin
        pipe_val_q <= rd;
        dval_q     <= pipe_val_q;
        for (int p = 0; p < 2; p++) begin
          if (rd[p]) begin
            pipe_q[p] <= rd_data[p];
          end
          if (pipe_val_q[p]) begin
            dout_q[p] <= pipe_q[p];
          end
        end
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        dval_q <= '0;
        dout_q <= '0;
      end else begin
        dval_q <= rd;
        for (int p = 0; p < 2; p++) begin
          if (rd[p]) begin
            dout_q[p] <= rd_data[p];
          end
        end
      end
    end
  end

  assign A_DOUT = dout_q[0];
  assign A_DVAL = dval_q[0];
  assign B_DOUT = dout_q[1];
  assign B_DVAL = dval_q[1];

`ifdef SRAM_2P_COLL_CHK_EN
  logic       coll_ev;
  logic       coll_flag_q;
  logic [7:0] coll_cnt_q;

  // An out-of-range address is never a collision, because it reaches no storage.
  assign coll_ev = men[0] & men[1] & valid[0] & valid[1] & (addr[0] == addr[1]) &
                   (wen[0] | wen[1]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      coll_flag_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else if (COLL_CLR) begin
      coll_flag_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else if (coll_ev) begin
      coll_flag_q <= 1'b1;
      if (coll_cnt_q != 8'hFF) begin
        coll_cnt_q <= coll_cnt_q + 8'd1;
      end
    end
  end

  assign COLL_FLAG = coll_flag_q;
  assign COLL_CNT  = coll_cnt_q;
`else
  logic unused_coll_clr;
  assign unused_coll_clr = COLL_CLR;
  assign COLL_FLAG       = 1'b0;
  assign COLL_CNT        = '0;
`endif

endmodule

// File: tb/tb_sram_2p_sync_bm.sv
// Bench for sram_2p_sync_bm. Two instances share all inputs:
//   u0: gran 8, read-during-write returns new word, no output reg, 1000 words, prio A
//   u1: gran 8, read-during-write returns old word, output reg, 1024 words, prio B
module tb_sram_2p_sync_bm;

`ifdef SRAM_2P_COLL_CHK_EN
  localparam int CollEn = 1;
`else
  localparam int CollEn = 0;
`endif

  typedef struct packed {
    logic        bist;
    logic        men;
    logic        wen;
    logic        ren;
    logic [9:0]  addr;
    logic [31:0] din;
    logic [3:0]  bm;
  } port_t;

  typedef struct packed {
    port_t       a;
    port_t       b;
    logic [31:0] ea_d;
    logic        ea_v;
    logic [31:0] eb_d;
    logic        eb_v;
    logic [31:0] fa_d;
    logic        fa_v;
    logic [31:0] fb_d;
    logic        fb_v;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        A_MEN, A_WEN, A_REN, A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
  logic [9:0]  A_ADDR, A_BIST_ADDR;
  logic [31:0] A_DIN, A_BIST_DIN;
  logic [3:0]  A_BM, A_BIST_BM;
  logic        B_MEN, B_WEN, B_REN, B_BIST_EN, B_BIST_MEN, B_BIST_WEN, B_BIST_REN;
  logic [9:0]  B_ADDR, B_BIST_ADDR;
  logic [31:0] B_DIN, B_BIST_DIN;
  logic [3:0]  B_BM, B_BIST_BM;
  logic        COLL_CLR;

  logic [31:0] u0_a_dout, u0_b_dout, u1_a_dout, u1_b_dout;
  logic        u0_a_dval, u0_b_dval, u1_a_dval, u1_b_dval;
  logic        u0_coll_flag, u1_coll_flag;
  logic [7:0]  u0_coll_cnt, u1_coll_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  sram_2p_sync_bm #(
    .P_DATA_WIDTH(32), .P_ADDR_WIDTH(10), .P_ADDR_COUNT(1000), .P_MASK_GRAN(8),
    .P_RDW_MODE(0), .P_OUT_REG(0), .P_COLL_PRIO(0)
  ) u0 (
    .CLK(CLK), .RST_N(RST_N),
    .A_MEN(A_MEN), .A_WEN(A_WEN), .A_REN(A_REN), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
    .A_BM(A_BM), .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
    .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
    .A_BIST_BM(A_BIST_BM), .A_DOUT(u0_a_dout), .A_DVAL(u0_a_dval),
    .B_MEN(B_MEN), .B_WEN(B_WEN), .B_REN(B_REN), .B_ADDR(B_ADDR), .B_DIN(B_DIN),
    .B_BM(B_BM), .B_BIST_EN(B_BIST_EN), .B_BIST_MEN(B_BIST_MEN), .B_BIST_WEN(B_BIST_WEN),
    .B_BIST_REN(B_BIST_REN), .B_BIST_ADDR(B_BIST_ADDR), .B_BIST_DIN(B_BIST_DIN),
    .B_BIST_BM(B_BIST_BM), .B_DOUT(u0_b_dout), .B_DVAL(u0_b_dval),
    .COLL_CLR(COLL_CLR), .COLL_FLAG(u0_coll_flag), .COLL_CNT(u0_coll_cnt)
  );

  sram_2p_sync_bm #(
    .P_DATA_WIDTH(32), .P_ADDR_WIDTH(10), .P_MASK_GRAN(8),
    .P_RDW_MODE(1), .P_OUT_REG(1), .P_COLL_PRIO(1)
  ) u1 (
    .CLK(CLK), .RST_N(RST_N),
    .A_MEN(A_MEN), .A_WEN(A_WEN), .A_REN(A_REN), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
    .A_BM(A_BM), .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
    .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
    .A_BIST_BM(A_BIST_BM), .A_DOUT(u1_a_dout), .A_DVAL(u1_a_dval),
    .B_MEN(B_MEN), .B_WEN(B_WEN), .B_REN(B_REN), .B_ADDR(B_ADDR), .B_DIN(B_DIN),
    .B_BM(B_BM), .B_BIST_EN(B_BIST_EN), .B_BIST_MEN(B_BIST_MEN), .B_BIST_WEN(B_BIST_WEN),
    .B_BIST_REN(B_BIST_REN), .B_BIST_ADDR(B_BIST_ADDR), .B_BIST_DIN(B_BIST_DIN),
    .B_BIST_BM(B_BIST_BM), .B_DOUT(u1_b_dout), .B_DVAL(u1_b_dval),
    .COLL_CLR(COLL_CLR), .COLL_FLAG(u1_coll_flag), .COLL_CNT(u1_coll_cnt)
  );

  function automatic port_t p_idle();
    p_idle = '0;
  endfunction

  function automatic port_t p_wr(input logic [9:0] ad, input logic [31:0] d,
                                 input logic [3:0] m);
    p_wr      = '0;
    p_wr.men  = 1'b1;
    p_wr.wen  = 1'b1;
    p_wr.addr = ad;
    p_wr.din  = d;
    p_wr.bm   = m;
  endfunction

  function automatic port_t p_rd(input logic [9:0] ad);
    p_rd      = '0;
    p_rd.men  = 1'b1;
    p_rd.ren  = 1'b1;
    p_rd.addr = ad;
  endfunction

  function automatic port_t p_wrd(input logic [9:0] ad, input logic [31:0] d);
    p_wrd     = p_wr(ad, d, 4'hF);
    p_wrd.ren = 1'b1;
  endfunction

  function automatic port_t p_bist(input port_t p);
    p_bist      = p;
    p_bist.bist = 1'b1;
  endfunction

  // The unselected side always carries a conflicting write, so a broken mux
  // shows up as corrupted data or a spurious DVAL.
  function automatic port_t p_junk(input port_t p);
    p_junk      = '0;
    p_junk.men  = 1'b1;
    p_junk.wen  = 1'b1;
    p_junk.ren  = 1'b1;
    p_junk.addr = p.addr ^ 10'd1;
    p_junk.din  = ~p.din;
    p_junk.bm   = 4'hF;
  endfunction

  task automatic drive_a(input port_t p);
    port_t f, s;
    f = p.bist ? p_junk(p) : p;
    s = p.bist ? p : p_junk(p);
    A_BIST_EN   = p.bist;
    A_MEN       = f.men;
    A_WEN       = f.wen;
    A_REN       = f.ren;
    A_ADDR      = f.addr;
    A_DIN       = f.din;
    A_BM        = f.bm;
    A_BIST_MEN  = s.men;
    A_BIST_WEN  = s.wen;
    A_BIST_REN  = s.ren;
    A_BIST_ADDR = s.addr;
    A_BIST_DIN  = s.din;
    A_BIST_BM   = s.bm;
  endtask

  task automatic drive_b(input port_t p);
    port_t f, s;
    f = p.bist ? p_junk(p) : p;
    s = p.bist ? p : p_junk(p);
    B_BIST_EN   = p.bist;
    B_MEN       = f.men;
    B_WEN       = f.wen;
    B_REN       = f.ren;
    B_ADDR      = f.addr;
    B_DIN       = f.din;
    B_BM        = f.bm;
    B_BIST_MEN  = s.men;
    B_BIST_WEN  = s.wen;
    B_BIST_REN  = s.ren;
    B_BIST_ADDR = s.addr;
    B_BIST_DIN  = s.din;
    B_BIST_BM   = s.bm;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_coll(input string name, input int u0_cnt, input int u1_cnt);
    chk({name, "_u0_flag"}, 32'(u0_coll_flag), 32'(u0_cnt != 0));
    chk({name, "_u0_cnt"},  32'(u0_coll_cnt),  32'(u0_cnt));
    chk({name, "_u1_flag"}, 32'(u1_coll_flag), 32'(u1_cnt != 0));
    chk({name, "_u1_cnt"},  32'(u1_coll_cnt),  32'(u1_cnt));
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{p_wr(10'd5, 32'hAABBCCDD, 4'hF), p_idle(),
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{p_wr(10'd5, 32'h11223344, 4'b0101), p_idle(),
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{p_rd(10'd5), p_wr(10'd3, 32'h0, 4'hF),
                 32'hAA22CC44, 1'b1, 32'h0, 1'b0, 32'hAA22CC44, 1'b1, 32'h0, 1'b0};
    vecs[3]  = '{p_wrd(10'd3, 32'hFFFF0000), p_rd(10'd5),
                 32'hFFFF0000, 1'b1, 32'hAA22CC44, 1'b1, 32'h0, 1'b1, 32'hAA22CC44, 1'b1};
    vecs[4]  = '{p_rd(10'd3), p_wr(10'd3, 32'h12345678, 4'hF),
                 32'hFFFF0000, 1'b1, 32'hAA22CC44, 1'b0, 32'hFFFF0000, 1'b1, 32'hAA22CC44, 1'b0};
    vecs[5]  = '{p_rd(10'd3), p_idle(),
                 32'h12345678, 1'b1, 32'hAA22CC44, 1'b0, 32'h12345678, 1'b1, 32'hAA22CC44, 1'b0};
    vecs[6]  = '{p_idle(), p_idle(),
                 32'h12345678, 1'b0, 32'hAA22CC44, 1'b0, 32'h12345678, 1'b0, 32'hAA22CC44, 1'b0};
    vecs[7]  = '{p_wr(10'd1010, 32'h55555555, 4'hF), p_idle(),
                 32'h12345678, 1'b0, 32'hAA22CC44, 1'b0, 32'h12345678, 1'b0, 32'hAA22CC44, 1'b0};
    vecs[8]  = '{p_rd(10'd1010), p_idle(),
                 32'h0, 1'b1, 32'hAA22CC44, 1'b0, 32'h55555555, 1'b1, 32'hAA22CC44, 1'b0};
    vecs[9]  = '{p_bist(p_wr(10'd2, 32'h12345678, 4'hF)), p_idle(),
                 32'h0, 1'b0, 32'hAA22CC44, 1'b0, 32'h55555555, 1'b0, 32'hAA22CC44, 1'b0};
    vecs[10] = '{p_idle(), p_rd(10'd2),
                 32'h0, 1'b0, 32'h12345678, 1'b1, 32'h55555555, 1'b0, 32'h12345678, 1'b1};
    vecs[11] = '{p_idle(), p_bist(p_rd(10'd5)),
                 32'h0, 1'b0, 32'hAA22CC44, 1'b1, 32'h55555555, 1'b0, 32'hAA22CC44, 1'b1};
    vecs[12] = '{p_idle(), p_idle(),
                 32'h0, 1'b0, 32'hAA22CC44, 1'b0, 32'h55555555, 1'b0, 32'hAA22CC44, 1'b0};

    RST_N    = 1'b0;
    COLL_CLR = 1'b0;
    drive_a(p_idle());
    drive_b(p_idle());
    step();
    step();
    chk("rst_u0_a_dout", u0_a_dout, 32'h0);
    chk("rst_u0_a_dval", 32'(u0_a_dval), 32'h0);
    chk("rst_u1_b_dout", u1_b_dout, 32'h0);
    chk("rst_u1_b_dval", 32'(u1_b_dval), 32'h0);
    chk_coll("rst", 0, 0);
    RST_N = 1'b1;

    // u1 lags one edge, so it is checked against the previous vector.
    for (int i = 0; i < 13; i++) begin
      drive_a(vecs[i].a);
      drive_b(vecs[i].b);
      step();
      chk($sformatf("v%0d_u0_a_dout", i), u0_a_dout, vecs[i].ea_d);
      chk($sformatf("v%0d_u0_a_dval", i), 32'(u0_a_dval), 32'(vecs[i].ea_v));
      chk($sformatf("v%0d_u0_b_dout", i), u0_b_dout, vecs[i].eb_d);
      chk($sformatf("v%0d_u0_b_dval", i), 32'(u0_b_dval), 32'(vecs[i].eb_v));
      if (i > 0) begin
        chk($sformatf("v%0d_u1_a_dout", i - 1), u1_a_dout, vecs[i-1].fa_d);
        chk($sformatf("v%0d_u1_a_dval", i - 1), 32'(u1_a_dval), 32'(vecs[i-1].fa_v));
        chk($sformatf("v%0d_u1_b_dout", i - 1), u1_b_dout, vecs[i-1].fb_d);
        chk($sformatf("v%0d_u1_b_dval", i - 1), 32'(u1_b_dval), 32'(vecs[i-1].fb_v));
      end
    end

    // Write-write collision on addr 7: u0 gives A priority, u1 gives B priority.
    COLL_CLR = 1'b1;
    drive_a(p_idle());
    drive_b(p_idle());
    step();
    COLL_CLR = 1'b0;
    chk_coll("clr", 0, 0);
    drive_a(p_wr(10'd7, 32'h0, 4'hF));
    step();
    drive_a(p_wr(10'd7, 32'h000000FF, 4'b0011));
    drive_b(p_wr(10'd7, 32'hFFFFFF00, 4'b0110));
    step();
    chk_coll("ww", CollEn, CollEn);
    drive_a(p_rd(10'd7));
    drive_b(p_idle());
    step();
    chk("ww_u0_a_dout", u0_a_dout, 32'h00FF00FF);
    chk("ww_u0_a_dval", 32'(u0_a_dval), 32'h1);
    drive_a(p_idle());
    step();
    chk("ww_u1_a_dout", u1_a_dout, 32'h00FFFFFF);
    chk("ww_u1_a_dval", 32'(u1_a_dval), 32'h1);

    // Saturation, then clear winning over a same-cycle event
    drive_a(p_wr(10'd7, 32'h0, 4'hF));
    drive_b(p_rd(10'd7));
    for (int i = 0; i < 300; i++) step();
    chk_coll("sat", 255 * CollEn, 255 * CollEn);
    COLL_CLR = 1'b1;
    step();
    chk_coll("clr_ev", 0, 0);
    COLL_CLR = 1'b0;
    step();
    chk_coll("ev_after_clr", CollEn, CollEn);
    COLL_CLR = 1'b1;
    drive_a(p_idle());
    drive_b(p_idle());
    step();
    COLL_CLR = 1'b0;

    // Addr 1010 is out of range for u0 only.
    drive_a(p_wr(10'd1010, 32'hFFFFFFFF, 4'hF));
    drive_b(p_rd(10'd1010));
    step();
    chk("oor_u0_b_dout", u0_b_dout, 32'h0);
    chk("oor_u0_b_dval", 32'(u0_b_dval), 32'h1);
    chk_coll("oor", 0, CollEn);
    drive_a(p_idle());
    drive_b(p_idle());
    step();
    chk("oor_u1_b_dout", u1_b_dout, 32'h55555555);
    chk("oor_u1_b_dval", 32'(u1_b_dval), 32'h1);

    // Reset while a u1 read is in its pipeline stage; a write during reset is dropped.
    drive_a(p_rd(10'd2));
    step();
    chk("prerst_u0_a_dout", u0_a_dout, 32'h12345678);
    RST_N = 1'b0;
    #1;
    chk("inrst_u0_a_dout", u0_a_dout, 32'h0);
    chk("inrst_u1_a_dval", 32'(u1_a_dval), 32'h0);
    drive_a(p_wr(10'd2, 32'hFFFFFFFF, 4'hF));
    step();
    chk("inrst_u1_a_dout", u1_a_dout, 32'h0);
    chk_coll("inrst", 0, 0);
    drive_a(p_idle());
    RST_N = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("postrst%0d_u1_a_dval", i), 32'(u1_a_dval), 32'h0);
      chk($sformatf("postrst%0d_u1_a_dout", i), u1_a_dout, 32'h0);
    end
    drive_a(p_rd(10'd2));
    step();
    chk("rstwr_u0_a_dout", u0_a_dout, 32'h12345678);
    chk("rstwr_u0_a_dval", 32'(u0_a_dval), 32'h1);
    drive_a(p_idle());
    step();
    chk("rstwr_u1_a_dout", u1_a_dout, 32'h12345678);
    chk("rstwr_u1_a_dval", 32'(u1_a_dval), 32'h1);
    chk("rstwr_u0_a_hold", 32'(u0_a_dval), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
